// File: rtl/iq_cov_pkg.sv
// Shared constants, the complex sample type and the R-matrix entry index helper
// for the 4-channel covariance engine.
package iq_cov_pkg;

  localparam int N_CH  = 4;
  localparam int DW    = 16;
  localparam int OUT_W = 512;
  localparam int SHIFT = 16;
  localparam int PW    = 2 * DW;      // one signed DWxDW product
  localparam int AW    = 2 * DW + 1;  // sum or difference of two products

  // im sits above re so a packed array of cplx_t lays out re in the low half of each entry
  typedef struct packed {
    logic signed [DW-1:0] im;
    logic signed [DW-1:0] re;
  } cplx_t;

  function automatic int entry_idx(input int i, input int j);
    return N_CH * i + j;
  endfunction

endpackage

// File: rtl/cmac_conj.sv
// Registered conjugate multiply y = xi * conj(xj): products in the first stage,
// then combine, arithmetic shift and saturation in the second.
module cmac_conj
  import iq_cov_pkg::*;
#(
  parameter int SH = SHIFT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en_mul,
  input  logic  en_out,
  input  cplx_t xi,
  input  cplx_t xj,
  output cplx_t y
);

  logic signed [PW-1:0] p_ii, p_qq, p_qi, p_iq;
  logic signed [AW-1:0] re_sum, im_sum, re_sh, im_sh;

  function automatic logic [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    if (v > $signed({{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}}))
      return {1'b0, {(DW-1){1'b1}}};
    else if (v < $signed({{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}}))
      return {1'b1, {(DW-1){1'b0}}};
    else
      return v[DW-1:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_ii <= '0;
      p_qq <= '0;
      p_qi <= '0;
      p_iq <= '0;
    end else if (en_mul) begin
      p_ii <= xi.re * xj.re;
      p_qq <= xi.im * xj.im;
      p_qi <= xi.im * xj.re;
      p_iq <= xi.re * xj.im;
    end
  end

  // Sign-extend before adding so the full 33-bit sum is kept; >>> floors.
  assign re_sum = AW'(p_ii) + AW'(p_qq);
  assign im_sum = AW'(p_qi) - AW'(p_iq);
  assign re_sh  = re_sum >>> SH;
  assign im_sh  = im_sum >>> SH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en_out) begin
      y.re <= sat_dw(re_sh);
      y.im <= sat_dw(im_sh);
    end
  end

endmodule

// File: rtl/iq_cov_prod.sv
// Streaming 4-channel complex outer product R = x*x^H, one 512-bit word per
// accepted sample set, three register stages from input to output.
module iq_cov_prod
  import iq_cov_pkg::*;
(
  input  logic             aclk,
  input  logic             rst,
  input  logic [DW-1:0]    axis_di0,
  input  logic [DW-1:0]    axis_di1,
  input  logic [DW-1:0]    axis_di2,
  input  logic [DW-1:0]    axis_di3,
  input  logic             axis_vi0,
  input  logic             axis_vi1,
  input  logic             axis_vi2,
  input  logic             axis_vi3,
  input  logic [DW-1:0]    axis_dq0,
  input  logic [DW-1:0]    axis_dq1,
  input  logic [DW-1:0]    axis_dq2,
  input  logic [DW-1:0]    axis_dq3,
  input  logic             axis_vq0,
  input  logic             axis_vq1,
  input  logic             axis_vq2,
  input  logic             axis_vq3,
  output logic             axis_ri0,
  output logic             axis_ri1,
  output logic             axis_ri2,
  output logic             axis_ri3,
  output logic             axis_rq0,
  output logic             axis_rq1,
  output logic             axis_rq2,
  output logic             axis_rq3,
  output logic [OUT_W-1:0] axis_do0,
  output logic             axis_vo0
);

  logic                   rdy;
  logic                   accept;
  logic                   v1, v2, v3;
  cplx_t [N_CH-1:0]       x_in;
  cplx_t [N_CH-1:0]       x_s1;
  cplx_t [N_CH*N_CH-1:0]  ent;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) rdy <= 1'b0;
    else     rdy <= 1'b1;
  end

  assign {axis_ri0, axis_ri1, axis_ri2, axis_ri3} = {4{rdy}};
  assign {axis_rq0, axis_rq1, axis_rq2, axis_rq3} = {4{rdy}};

  // Only a complete set of all eight lanes is taken; partial sets are dropped.
  assign accept = rdy & axis_vi0 & axis_vi1 & axis_vi2 & axis_vi3
                      & axis_vq0 & axis_vq1 & axis_vq2 & axis_vq3;

  assign x_in[0] = '{im: axis_dq0, re: axis_di0};
  assign x_in[1] = '{im: axis_dq1, re: axis_di1};
  assign x_in[2] = '{im: axis_dq2, re: axis_di2};
  assign x_in[3] = '{im: axis_dq3, re: axis_di3};

  // NOTE: every data register is cleared by reset, so axis_do0 reads zero after
  // reset instead of stale products.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      x_s1 <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (accept) x_s1 <= x_in;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_row
    for (genvar j = 0; j < N_CH; j++) begin : g_col
      cmac_conj #(.SH(SHIFT)) u_cmac (
        .clk    (aclk),
        .rst    (rst),
        .en_mul (v1),
        .en_out (v2),
        .xi     (x_s1[i]),
        .xj     (x_s1[j]),
        .y      (ent[entry_idx(i, j)])
      );
    end
  end

  assign axis_do0 = ent;
  assign axis_vo0 = v3;

endmodule

// File: tb/tb_iq_cov_prod.sv
// Directed self-checking bench for iq_cov_prod: hand-computed vectors plus a
// small integer reference model for the streaming burst.
module tb_iq_cov_prod;

  logic         aclk = 1'b0;
  logic         rst  = 1'b1;
  logic [15:0]  di [4];
  logic [15:0]  dq [4];
  logic         vi [4];
  logic         vq [4];
  logic         ri [4];
  logic         rq [4];
  logic [511:0] do0;
  logic         vo0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  iq_cov_prod dut (
    .aclk     (aclk),
    .rst      (rst),
    .axis_di0 (di[0]), .axis_di1 (di[1]), .axis_di2 (di[2]), .axis_di3 (di[3]),
    .axis_vi0 (vi[0]), .axis_vi1 (vi[1]), .axis_vi2 (vi[2]), .axis_vi3 (vi[3]),
    .axis_dq0 (dq[0]), .axis_dq1 (dq[1]), .axis_dq2 (dq[2]), .axis_dq3 (dq[3]),
    .axis_vq0 (vq[0]), .axis_vq1 (vq[1]), .axis_vq2 (vq[2]), .axis_vq3 (vq[3]),
    .axis_ri0 (ri[0]), .axis_ri1 (ri[1]), .axis_ri2 (ri[2]), .axis_ri3 (ri[3]),
    .axis_rq0 (rq[0]), .axis_rq1 (rq[1]), .axis_rq2 (rq[2]), .axis_rq3 (rq[3]),
    .axis_do0 (do0),
    .axis_vo0 (vo0)
  );

  function automatic logic [7:0] ready_bits();
    return {ri[0], ri[1], ri[2], ri[3], rq[0], rq[1], rq[2], rq[3]};
  endfunction

  function automatic logic [15:0] sat_shift(input longint v);
    longint s;
    s = v >>> 16;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [511:0] model(input logic [63:0] iv, input logic [63:0] qv);
    logic [511:0] w;
    longint ii, qi, ij, qj;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ii = longint'($signed(iv[16*i +: 16]));
        qi = longint'($signed(qv[16*i +: 16]));
        ij = longint'($signed(iv[16*j +: 16]));
        qj = longint'($signed(qv[16*j +: 16]));
        w[32*(4*i+j) +: 16]      = sat_shift(ii * ij + qi * qj);
        w[32*(4*i+j) + 16 +: 16] = sat_shift(qi * ij - ii * qj);
      end
    end
    return w;
  endfunction

  function automatic logic [63:0] pat_i(input int c);
    logic [63:0] v;
    for (int ch = 0; ch < 4; ch++) v[16*ch +: 16] = 16'((c + 1) * 'h0800 + ch * 'h0123);
    return v;
  endfunction

  function automatic logic [63:0] pat_q(input int c);
    logic [63:0] v;
    for (int ch = 0; ch < 4; ch++) v[16*ch +: 16] = 16'(ch * 'h0211 - (c + 1) * 'h0300);
    return v;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [63:0] iv, input logic [63:0] qv, input logic v);
    for (int ch = 0; ch < 4; ch++) begin
      di[ch] = iv[16*ch +: 16];
      dq[ch] = qv[16*ch +: 16];
      vi[ch] = v;
      vq[ch] = v;
    end
  endtask

  // One valid cycle, then idle; records axis_vo0 after each of the next five edges.
  task automatic send_single(input logic [63:0] iv, input logic [63:0] qv,
                             output logic [4:0] hist, output logic [511:0] d3,
                             output logic [511:0] d5);
    drive(iv, qv, 1'b1);
    for (int e = 0; e < 5; e++) begin
      tick();
      if (e == 0) drive('0, '0, 1'b0);
      hist[e] = vo0;
      if (e == 2) d3 = do0;
      if (e == 4) d5 = do0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, '0, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (ready_bits() !== 8'h00) begin
      n_bad++; $display("FAIL reset_ready: got %h want 00", ready_bits());
    end
    n_cmp++;
    if (vo0 !== 1'b0 || do0 !== '0) begin
      n_bad++; $display("FAIL reset_out: vo=%b do_nonzero=%b want vo=0 do=0", vo0, |do0);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready_bits() !== 8'h00) begin
      n_bad++; $display("FAIL ready_before_edge: got %h want 00", ready_bits());
    end
    tick();
    n_cmp++;
    if (ready_bits() !== 8'hFF) begin
      n_bad++; $display("FAIL ready_after_edge: got %h want ff", ready_bits());
    end
  endtask

  task automatic test_impulse();
    logic [4:0]   hist;
    logic [511:0] d3, d5, exp_w;
    exp_w = '0;
    exp_w[15:0] = 16'h1000;
    send_single(64'h0000_0000_0000_4000, 64'h0, hist, d3, d5);
    n_cmp++;
    if (hist !== 5'b00100) begin
      n_bad++; $display("FAIL impulse_valid: history %b want 00100", hist);
    end
    n_cmp++;
    if (d3 !== exp_w) begin
      n_bad++; $display("FAIL impulse_data: entry0 %h low_rest_nonzero=%b want 00001000", d3[31:0], |d3[511:32]);
    end
    n_cmp++;
    if (d5 !== exp_w) begin
      n_bad++; $display("FAIL impulse_hold: entry0 %h want 00001000", d5[31:0]);
    end
  endtask

  task automatic test_cross();
    logic [4:0]   hist;
    logic [511:0] d3, d5;
    logic [63:0]  iv, qv;
    iv = 64'h0000_0000_0000_4000;
    qv = 64'h0000_0000_4000_0000;
    send_single(iv, qv, hist, d3, d5);
    n_cmp++;
    if (d3[63:32] !== 32'hF000_0000) begin
      n_bad++; $display("FAIL cross_r01: got %h want f0000000", d3[63:32]);
    end
    n_cmp++;
    if (d3[159:128] !== 32'h1000_0000) begin
      n_bad++; $display("FAIL cross_r10: got %h want 10000000", d3[159:128]);
    end
    n_cmp++;
    if (d3[191:160] !== 32'h0000_1000) begin
      n_bad++; $display("FAIL cross_r11: got %h want 00001000", d3[191:160]);
    end
    n_cmp++;
    if (d3 !== model(iv, qv)) begin
      n_bad++; $display("FAIL cross_word: got %h want %h", d3[255:0], model(iv, qv) >> 0);
    end
  endtask

  task automatic test_saturate();
    logic [4:0]   hist;
    logic [511:0] d3, d5, exp_w;
    exp_w = '0;
    exp_w[15:0] = 16'h7FFF;
    send_single(64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, hist, d3, d5);
    n_cmp++;
    if (hist !== 5'b00100) begin
      n_bad++; $display("FAIL sat_valid: history %b want 00100", hist);
    end
    n_cmp++;
    if (d3 !== exp_w) begin
      n_bad++; $display("FAIL sat_data: entry0 %h rest_nonzero=%b want 00007fff", d3[31:0], |d3[511:32]);
    end
  endtask

  task automatic test_partial();
    logic [511:0] held;
    held = do0;
    drive(pat_i(3), pat_q(3), 1'b1);
    vq[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) drive('0, '0, 1'b0);
      tick();
      n_cmp++;
      if (vo0 !== 1'b0 || do0 !== held) begin
        n_bad++; $display("FAIL partial_c%0d: vo=%b changed=%b want vo=0 unchanged", c, vo0, do0 !== held);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] exp_w [10];
    int           seen;
    logic         want_v;
    seen = 0;
    for (int c = 0; c < 10; c++) exp_w[c] = model(pat_i(c), pat_q(c));
    for (int c = 0; c < 13; c++) begin
      if (c < 10) drive(pat_i(c), pat_q(c), 1'b1);
      else        drive('0, '0, 1'b0);
      tick();
      want_v = (c >= 2) && (c < 12);
      n_cmp++;
      if (vo0 !== want_v) begin
        n_bad++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, vo0, want_v);
      end
      if (want_v && vo0 === 1'b1) begin
        seen++;
        n_cmp++;
        if (do0 !== exp_w[c-2]) begin
          n_bad++; $display("FAIL b2b_data_%0d: got %h want %h", c - 2, do0[127:0], exp_w[c-2][127:0]);
        end
      end
    end
    n_cmp++;
    if (seen != 10) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 10", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0]   hist;
    logic [511:0] d3, d5, exp_w;
    for (int c = 0; c < 4; c++) begin
      drive(pat_i(c), pat_q(c), 1'b1);
      tick();
    end
    n_cmp++;
    if (vo0 !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre_valid: got %b want 1", vo0);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (vo0 !== 1'b0 || do0 !== '0 || ready_bits() !== 8'h00) begin
      n_bad++; $display("FAIL mid_async_drop: vo=%b do_nonzero=%b ready=%h want 0/0/00", vo0, |do0, ready_bits());
    end
    drive('0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (vo0 !== 1'b0) begin
        n_bad++; $display("FAIL mid_stale_c%0d: got vo=%b want 0", c, vo0);
      end
    end
    exp_w = '0;
    exp_w[15:0] = 16'h1000;
    send_single(64'h0000_0000_0000_4000, 64'h0, hist, d3, d5);
    n_cmp++;
    if (hist !== 5'b00100 || d3 !== exp_w) begin
      n_bad++; $display("FAIL mid_recover: history %b entry0 %h want 00100 00001000", hist, d3[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_cross();
    test_saturate();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
